// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jk_bank_ctrl
//  Brief    : Command sequencer driving j/k of a bank of JK flip-flops.
//  Revision : 1.0
// ============================================================================
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_COUNT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_OP_CLEAR  = 3'd1;
    localparam logic [2:0] C_OP_SET    = 3'd2;
    localparam logic [2:0] C_OP_TOGGLE = 3'd3;
    localparam logic [2:0] C_OP_COUNT  = 3'd4;

    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_carry;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        C_OP_CLEAR, C_OP_SET, C_OP_TOGGLE: w_next = S_APPLY;
                        C_OP_COUNT: w_next = (cmd_steps != C_CNT_ZERO) ? S_COUNT : S_DONE;
                        default:    w_next = S_DONE;
                    endcase
                end
            end
            S_APPLY: w_next = S_DONE;
            // The step sampled together with abort still completes this cycle.
            S_COUNT: begin
                if ((r_cnt == C_CNT_ONE) || abort) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch and step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 3'd0;
            r_mask <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else if ((r_state == S_IDLE) && cmd_valid) begin
            r_op   <= cmd_op;
            r_mask <= cmd_mask;
            r_cnt  <= cmd_steps;
            r_err  <= (cmd_op > C_OP_COUNT);
        end else if (r_state == S_COUNT) begin
            r_cnt  <= r_cnt - C_CNT_ONE;
        end
    end

    // Increment as a ripple of T-flops: bit i toggles when all lower bits are 1.
    assign w_carry[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_carry
        assign w_carry[gi] = &r_q[gi-1:0];
    end

    // ------------------------------------------------------------------
    // Output logic (registers and state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_j       = '0;
        w_k       = '0;
        cmd_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        err       = (r_state == S_DONE) && r_err;
        case (r_state)
            S_APPLY: begin
                case (r_op)
                    C_OP_CLEAR:  w_k = r_mask;
                    C_OP_SET:    w_j = r_mask;
                    C_OP_TOGGLE: begin
                        w_j = r_mask;
                        w_k = r_mask;
                    end
                    default: begin
                        w_j = '0;
                        w_k = '0;
                    end
                endcase
            end
            S_COUNT: begin
                w_j = w_carry;
                w_k = w_carry;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    // JK bank: q+ = j & ~q | ~k & q, per bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
        end
    end

    assign jk_j = w_j;
    assign jk_k = w_k;
    assign q    = r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_bank_ctrl
//  Brief    : Self-checking bench for jk_bank_ctrl with a behavioural model.
//  Revision : 1.0
// ============================================================================
module tb_jk_bank_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_steps;
    logic             abort;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             err;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q_model;
    int         lat;
    logic       err_seen;
    logic [7:0] q_done;

    jk_bank_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_mask  (cmd_mask),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .jk_j      (jk_j),
        .jk_k      (jk_k),
        .q         (q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: effect of a whole command on the bank value.
    function automatic logic [7:0] model_q(input logic [2:0] op, input logic [7:0] m,
                                           input logic [7:0] s, input logic [7:0] qi);
        case (op)
            3'd1:    return qi & ~m;
            3'd2:    return qi | m;
            3'd3:    return qi ^ m;
            3'd4:    return qi + s;
            default: return qi;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [7:0] s);
        if (op >= 3'd1 && op <= 3'd3) return 2;
        if (op == 3'd4 && s != 8'd0) return int'(s) + 1;
        return 1;
    endfunction

    // Issues one command from IDLE, waits for done, returns to IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] m, input logic [7:0] s,
                           output int l, output logic e, output logic [7:0] qd);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = m;
        cmd_steps = s;
        tick;
        cmd_valid = 1'b0;
        l = 1;
        while (!done && l < 400) begin
            tick;
            l++;
        end
        e  = err;
        qd = q;
        if (done) tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({q, jk_j, jk_k} !== 24'h0) begin
            errors++;
            $display("FAIL reset_q_jk: got q=%h j=%h k=%h expected all 00", q, jk_j, jk_k);
        end
        checks++;
        if ({cmd_ready, busy, done, err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got rdy/busy/done/err=%b expected 1000", {cmd_ready, busy, done, err});
        end
        rst = 1'b0;
        tick;
        q_model = 8'h00;
    endtask

    task automatic test_set_clear;
        run_cmd(3'd2, 8'hFF, 8'd0, lat, err_seen, q_done);
        checks++;
        if (lat !== 2 || q_done !== 8'hFF) begin
            errors++;
            $display("FAIL set_ff: got lat=%0d q=%h expected lat=2 q=ff", lat, q_done);
        end
        run_cmd(3'd1, 8'h0F, 8'd0, lat, err_seen, q_done);
        checks++;
        if (lat !== 2 || q_done !== 8'hF0) begin
            errors++;
            $display("FAIL clear_0f: got lat=%0d q=%h expected lat=2 q=f0", lat, q_done);
        end
        q_model = 8'hF0;
    endtask

    task automatic test_toggle;
        run_cmd(3'd1, 8'hFF, 8'd0, lat, err_seen, q_done);
        run_cmd(3'd2, 8'hA5, 8'd0, lat, err_seen, q_done);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_mask  = 8'hFF;
        tick;
        cmd_valid = 1'b0;
        checks++;
        if (jk_j !== 8'hFF || jk_k !== 8'hFF || q !== 8'hA5) begin
            errors++;
            $display("FAIL toggle_apply: got j=%h k=%h q=%h expected j=ff k=ff q=a5", jk_j, jk_k, q);
        end
        tick;
        checks++;
        if (jk_j !== 8'h00 || jk_k !== 8'h00 || q !== 8'h5A || done !== 1'b1) begin
            errors++;
            $display("FAIL toggle_done: got j=%h k=%h q=%h done=%b expected 00 00 5a 1", jk_j, jk_k, q, done);
        end
        tick;
        q_model = 8'h5A;
    endtask

    task automatic test_count;
        logic [7:0] exp_seq [4];
        int         bc;
        int         dl;
        exp_seq = '{8'hFF, 8'h00, 8'h01, 8'h02};
        run_cmd(3'd1, 8'hFF, 8'd0, lat, err_seen, q_done);
        run_cmd(3'd2, 8'hFE, 8'd0, lat, err_seen, q_done);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_steps = 8'd4;
        tick;
        cmd_valid = 1'b0;
        bc = 0;
        dl = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) bc++;
            if (done && dl == 0) dl = i + 1;
            if (i >= 1 && i <= 4) begin
                checks++;
                if (q !== exp_seq[i-1]) begin
                    errors++;
                    $display("FAIL count_step%0d: got q=%h expected %h", i, q, exp_seq[i-1]);
                end
            end
            tick;
        end
        checks++;
        if (dl !== 5 || bc !== 5) begin
            errors++;
            $display("FAIL count_timing: got done_lat=%0d busy_cycles=%0d expected 5 and 5", dl, bc);
        end
        q_model = 8'h02;
    endtask

    task automatic test_abort;
        run_cmd(3'd1, 8'hFF, 8'd0, lat, err_seen, q_done);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_steps = 8'd10;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if (q !== 8'h03 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort: got q=%h done=%b expected q=03 done=1", q, done);
        end
        tick;
        run_cmd(3'd4, 8'hFF, 8'd0, lat, err_seen, q_done);
        checks++;
        if (lat !== 1 || q_done !== 8'h03 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL count_zero: got lat=%0d q=%h err=%b expected 1 03 0", lat, q_done, err_seen);
        end
        q_model = 8'h03;
    endtask

    task automatic test_illegal;
        run_cmd(3'd6, 8'hFF, 8'd3, lat, err_seen, q_done);
        checks++;
        if (lat !== 1 || err_seen !== 1'b1 || q_done !== q_model) begin
            errors++;
            $display("FAIL illegal_op6: got lat=%0d err=%b q=%h expected 1 1 %h", lat, err_seen, q_done, q_model);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done && err) n++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL b2b_illegal: got %0d err pulses expected 3", n);
        end
        tick;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_mask  = 8'h01;
        for (int i = 0; i < 9; i++) begin
            tick;
            if (done) n++;
        end
        cmd_valid = 1'b0;
        q_model = q_model ^ 8'h01;
        checks++;
        if (n !== 3 || q !== q_model) begin
            errors++;
            $display("FAIL b2b_toggle: got %0d done pulses q=%h expected 3 q=%h", n, q, q_model);
        end
    endtask

    task automatic test_random;
        logic [2:0] op;
        logic [7:0] m;
        logic [7:0] s;
        for (int it = 0; it < 30; it++) begin
            op = 3'($urandom_range(7, 0));
            m  = 8'($urandom);
            s  = 8'($urandom_range(12, 0));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick;
            run_cmd(op, m, s, lat, err_seen, q_done);
            q_model = model_q(op, m, s, q_model);
            checks++;
            if (lat !== model_lat(op, s) || q_done !== q_model || err_seen !== (op >= 3'd5)) begin
                errors++;
                $display("FAIL rand%0d op=%0d: got lat=%0d q=%h err=%b expected lat=%0d q=%h err=%b",
                         it, op, lat, q_done, err_seen, model_lat(op, s), q_model, (op >= 3'd5));
            end
        end
    endtask

    task automatic test_reset_mid_count;
        run_cmd(3'd2, 8'h3C, 8'd0, lat, err_seen, q_done);
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_steps = 8'd20;
        tick;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rst = 1'b1;
        tick;
        checks++;
        if (q !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_count: got q=%h busy=%b rdy=%b done=%b expected 00 0 1 0",
                     q, busy, cmd_ready, done);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
        q_model = 8'h00;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_mask  = '0;
        cmd_steps = '0;
        abort     = 1'b0;
        q_model   = 8'h00;
        test_reset;
        test_set_clear;
        test_toggle;
        test_count;
        test_abort;
        test_illegal;
        test_back_to_back;
        test_random;
        test_reset_mid_count;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
